// File: rtl/shift_unit_seq.sv
// shift_unit_seq
// Sequential shifter for the datapath shift stage. When start is accepted in
// IDLE, the operand and a shift amount taken from one of NSRC packed sources
// are latched. The operand is then shifted one bit per clock until the amount
// is used up, after which a one-cycle done pulse is raised.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   start      - shift request, only looked at in IDLE
//   op         - 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   sel        - index of the shift-amount source
//   shamt_src  - packed shift-amount sources, source i at [i*SHAMT_W +: SHAMT_W]
//   data_in    - operand
//   data_out   - result register
//   busy       - high while shifting
//   done       - one-cycle completion pulse
//   err        - one-cycle pulse when start arrives with an out-of-range sel
module shift_unit_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int NSRC    = 3,
    localparam int SEL_W  = $clog2(NSRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NSRC*SHAMT_W-1:0]  shamt_src,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 sel_ok;
    logic [SHAMT_W-1:0]   sel_amt;
    logic [DATA_W-1:0]    shifted;

    // Source selection. Indices outside 0..NSRC-1 select nothing, so the
    // mux never indexes past the packed source vector.
    always_comb begin
        sel_amt = '0;
        sel_ok  = (int'(sel) < NSRC);
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                sel_amt = shamt_src[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    // One-bit step of the latched operation applied to the result register.
    always_comb begin
        shifted = data_q;
        case (op_q)
            2'b00:   shifted = {data_q[DATA_W-2:0], 1'b0};
            2'b01:   shifted = {1'b0, data_q[DATA_W-1:1]};
            2'b10:   shifted = {data_q[DATA_W-1], data_q[DATA_W-1:1]};
            default: shifted = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
        endcase
    end

    // Next-state logic. busy and done are derived from the next state so that
    // they are registered alongside it and track the state exactly.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        data_d  = data_in;
                        op_d    = op;
                        cnt_d   = sel_amt;
                        state_d = (sel_amt == '0) ? DONE : SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                data_d = shifted;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset clears everything without an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq
// Directed bench for shift_unit_seq with hand-computed expected results,
// covering reset, each shift operation, zero and full-width amounts, an
// out-of-range select, a start ignored mid-shift and reset during a shift.
module tb_shift_unit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [14:0] shamt_src;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        err;

    int testsRun;
    int testsFailed;

    shift_unit_seq #(
        .DATA_W  (32),
        .SHAMT_W (5),
        .NSRC    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .sel       (sel),
        .shamt_src (shamt_src),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launches one shift and follows it to completion, checking the result,
    // the number of busy cycles, the start-to-done latency and that done is a
    // single-cycle pulse. A nonzero injectAt pulses start (with a different
    // operand) at that cycle of the operation, which must be ignored.
    task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                                 input logic [1:0] selIn, input logic [31:0] dataIn,
                                 input logic [31:0] expData, input int expBusy,
                                 input int expLat, input int injectAt);
        int   busyCnt;
        int   lat;
        logic sawDone;
        logic [31:0] res;
        busyCnt = 0;
        lat     = 0;
        sawDone = 1'b0;
        res     = '0;
        @(negedge clk);
        op      = opIn;
        sel     = selIn;
        data_in = dataIn;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 100 && !sawDone; c++) begin
            if (c == injectAt) begin
                start   = 1'b1;
                data_in = 32'hDEADBEEF;
                sel     = 2'd0;
            end else begin
                start = 1'b0;
            end
            if (busy) busyCnt++;
            if (done) begin
                sawDone = 1'b1;
                lat     = c;
                res     = data_out;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(sawDone), 32'd1);
        checkOutput({tag, "_data"}, res, expData);
        checkOutput({tag, "_busy_cycles"}, busyCnt, expBusy);
        checkOutput({tag, "_latency"}, lat, expLat);
        @(negedge clk);
        checkOutput({tag, "_done_single"}, 32'(done), 32'd0);
        checkOutput({tag, "_data_hold"}, data_out, expData);
    endtask

    initial begin
        logic [31:0] prev;
        logic        doneDuringReset;
        testsRun    = 0;
        testsFailed = 0;
        start       = 1'b0;
        op          = 2'b00;
        sel         = 2'd0;
        shamt_src   = '0;
        data_in     = '0;
        reset       = 1'b1;

        // Reset state.
        #2;
        checkOutput("rst_data", data_out, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Sources: src0=0, src1=4, src2=31.
        shamt_src = {5'd31, 5'd4, 5'd0};
        applyStimulus("sll4", 2'b00, 2'd1, 32'h00000001, 32'h00000010, 4, 5, 0);
        applyStimulus("sra31", 2'b10, 2'd2, 32'h80000000, 32'hFFFFFFFF, 31, 32, 0);
        applyStimulus("sll31", 2'b00, 2'd2, 32'h00000001, 32'h80000000, 31, 32, 0);
        applyStimulus("zero", 2'b01, 2'd0, 32'h12345678, 32'h12345678, 0, 1, 0);

        // Sources: src0=1 for the rotate.
        shamt_src = {5'd31, 5'd4, 5'd1};
        applyStimulus("rol1", 2'b11, 2'd0, 32'h80000001, 32'h00000003, 1, 2, 0);

        // Out-of-range select: err pulse only, result register untouched.
        @(negedge clk);
        prev    = data_out;
        sel     = 2'd3;
        op      = 2'b00;
        data_in = 32'hCAFEF00D;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("bad_err", 32'(err), 32'd1);
        checkOutput("bad_busy", 32'(busy), 32'd0);
        checkOutput("bad_done", 32'(done), 32'd0);
        checkOutput("bad_data", data_out, prev);
        @(negedge clk);
        checkOutput("bad_err_clear", 32'(err), 32'd0);
        checkOutput("bad_still_idle", 32'(busy), 32'd0);

        // Start pulsed mid-shift must not disturb result or latency.
        applyStimulus("ignore", 2'b00, 2'd1, 32'h00000003, 32'h00000030, 4, 5, 2);

        // Reset in the middle of an SRL by 8, after three shifts.
        shamt_src = {5'd31, 5'd8, 5'd1};
        @(negedge clk);
        op      = 2'b01;
        sel     = 2'd1;
        data_in = 32'hF0000000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_data", data_out, 32'h1E000000);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_data", data_out, 32'h0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        doneDuringReset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) doneDuringReset = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) doneDuringReset = 1'b1;
        end
        checkOutput("mid_no_done", 32'(doneDuringReset), 32'd0);
        applyStimulus("srl8", 2'b01, 2'd1, 32'hF0000000, 32'h00F00000, 8, 9, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
